game_screen_ctrl: RTL and testbench
===================================

// Module: game_screen_ctrl
// PURPOSE
//  Top-level screen sequencer for the Pong console. Tracks attract/countdown/play/game-over,
//  drives the enables for the title, start-prompt, countdown and winner text overlays,
//  gates the ball/paddle datapath (game_run, ball_serve) and keeps the score.
//  Advances on frame_tick pulses from the VGA timing block, key_press from the input
//  debouncer and point_p1/point_p2 from the ball logic.
// PARAMETERS
//  BLINK_FRAMES      30   frames per half-period of the "Press any key to start" blink
//  COUNT_FROM        3    first countdown digit shown before each serve (1..9)
//  FRAMES_PER_COUNT  60   frames each countdown digit is held
//  WIN_SCORE         7    score that ends the game (<= 2**SCORE_W-1)
//  OVER_FRAMES       180  frames the winner screen is held before returning to attract
//  SCORE_W           4    score register width
// PORTS
//  clk_0        in   1        pixel clock
//  rst          in   1        asynchronous reset, active-high
//  frame_tick   in   1        one-cycle pulse per frame (start of vertical blank)
//  key_press    in   1        one-cycle pulse, debounced, any key
//  point_p1     in   1        one-cycle pulse, player 1 scored
//  point_p2     in   1        one-cycle pulse, player 2 scored
//  show_title   out  1        enable "PONG" overlay
//  show_start   out  1        enable start-prompt overlay (blinking)
//  show_count   out  1        enable countdown digit overlay
//  count_digit  out  4        countdown digit to render
//  show_winner  out  1        enable winner overlay
//  winner       out  1        0 = player 1, 1 = player 2 (valid while show_winner)
//  game_run     out  1        ball/paddle motion enable
//  ball_serve   out  1        one-cycle pulse: recentre and launch ball
//  score_p1     out  SCORE_W  player 1 score
//  score_p2     out  SCORE_W  player 2 score
// BEHAVIOUR
//  - All outputs registered. Reset (async): state=ATTRACT, show_title=1, show_start=1, other
//    enables 0, count_digit=0, winner=0, scores 0, frame counter 0. Reset mid-play aborts.
//  - ATTRACT: show_title=1; show_start toggles on the frame_tick that completes BLINK_FRAMES
//    ticks. key_press -> COUNTDOWN next cycle: scores<=0, count_digit<=COUNT_FROM, counter<=0,
//    show_start<=1 (ready for next attract). key_press beats a same-cycle frame_tick.
//  - COUNTDOWN: show_count=1. Each frame_tick increments counter; at the tick completing
//    FRAMES_PER_COUNT: if count_digit==1 -> PLAY with ball_serve=1 for exactly that first
//    PLAY cycle; else count_digit-1, counter<=0. key_press and point pulses ignored.
//  - PLAY: game_run=1. point_p1 (priority over same-cycle point_p2, which is dropped)
//    or point_p2 increments that score. If new score == WIN_SCORE -> GAME_OVER,
//    winner set, game_run<=0; else -> COUNTDOWN (digit reload, counter<=0). frame_tick ignored.
//  - GAME_OVER: show_winner=1, show_title=1, scores held; after OVER_FRAMES frame_ticks
//    -> ATTRACT (scores held until next key_press). key_press ignored.
//  - Scores never exceed WIN_SCORE; no wrap. Counter width = $clog2 of the largest frame
//    parameter + 1; counter compares against param-1, never wraps silently.
//  - Exactly one of {show_start-phase ATTRACT, show_count, game_run, show_winner} state
//    group active at a time; transitions take one clock, no idle cycles.
// STRUCTURE
//  - pong_defs.vh (shared include): state encodings ST_ATTRACT=0, ST_COUNTDOWN=1,
//    ST_PLAY=2, ST_GAME_OVER=3; default frame constants reused by the text/VGA blocks.
//  - Sub-module frame_divider: counts frame_tick with sync clear, terminal-count compare
//    input, one-cycle done pulse; one instance shared by blink, countdown and over timers.
//  - Main FSM + score registers in this module.
// TESTING (bench params: BLINK_FRAMES=2, FRAMES_PER_COUNT=2, COUNT_FROM=3, WIN_SCORE=2,
//  OVER_FRAMES=3)
//  1 Reset, 5 frame_ticks -> show_start 1,1,0,0,1 pattern after ticks 2 and 4 toggle; title=1.
//  2 key_press -> next cycle show_count=1, digit=3; 6 ticks -> digits 3,2,1 then PLAY,
//    ball_serve high exactly 1 cycle, game_run=1.
//  3 PLAY, point_p2 -> score_p2=1, back to COUNTDOWN digit=3; point pulses there ignored.
//  4 point_p1 and point_p2 same cycle -> only score_p1 increments.
//  5 Score p1 to 2 -> GAME_OVER, winner=0, game_run=0; 3 ticks -> ATTRACT, scores held
//    until key_press clears them to 0.
//  6 Assert rst mid-COUNTDOWN (between edges) -> outputs at reset values immediately.

Source files
------------

// File: rtl/game_screen_ctrl_pkg.sv
// Shared definitions for the Pong screen sequencer: state encodings,
// default frame constants used by the text/VGA blocks, and a sizing helper.
package game_screen_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_ATTRACT   = 2'd0,
      ST_COUNTDOWN = 2'd1,
      ST_PLAY      = 2'd2,
      ST_GAME_OVER = 2'd3
   } state_t;

   localparam int unsigned DEF_BLINK_FRAMES     = 30;
   localparam int unsigned DEF_COUNT_FROM       = 3;
   localparam int unsigned DEF_FRAMES_PER_COUNT = 60;
   localparam int unsigned DEF_WIN_SCORE        = 7;
   localparam int unsigned DEF_OVER_FRAMES      = 180;
   localparam int unsigned DEF_SCORE_W          = 4;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/game_screen_ctrl_if.sv
// Frame/key/point event inputs and overlay/datapath control outputs of the
// screen sequencer, bundled for the console top level.
interface game_screen_ctrl_if #(
   parameter int unsigned SCORE_W = 4
);
   logic               frame_tick;
   logic               key_press;
   logic               point_p1;
   logic               point_p2;
   logic               show_title;
   logic               show_start;
   logic               show_count;
   logic [3:0]         count_digit;
   logic               show_winner;
   logic               winner;
   logic               game_run;
   logic               ball_serve;
   logic [SCORE_W-1:0] score_p1;
   logic [SCORE_W-1:0] score_p2;

   modport master (
      output frame_tick, key_press, point_p1, point_p2,
      input  show_title, show_start, show_count, count_digit, show_winner,
             winner, game_run, ball_serve, score_p1, score_p2
   );

   modport slave (
      input  frame_tick, key_press, point_p1, point_p2,
      output show_title, show_start, show_count, count_digit, show_winner,
             winner, game_run, ball_serve, score_p1, score_p2
   );
endinterface

// File: rtl/game_screen_ctrl_frame_divider.sv
// Frame tick counter with synchronous clear and a runtime terminal count;
// done pulses on the tick that completes term+1 ticks.
module frame_divider #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             tick,
   input  logic [CNT_W-1:0] term,
   output logic             done
);
   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (tick) begin
         // >= so a lowered terminal count after a timer switch still wraps
         if (count >= term) count <= '0;
         else               count <= count + CNT_W'(1);
      end
   end

   assign done = tick && !clr && (count >= term);
endmodule

// File: rtl/game_screen_ctrl.sv
// Pong screen sequencer: attract / countdown / play / game-over FSM, overlay
// enables, ball/paddle gating and score keeping.
module game_screen_ctrl
   import game_screen_ctrl_pkg::*;
#(
   parameter int unsigned BLINK_FRAMES     = DEF_BLINK_FRAMES,
   parameter int unsigned COUNT_FROM       = DEF_COUNT_FROM,
   parameter int unsigned FRAMES_PER_COUNT = DEF_FRAMES_PER_COUNT,
   parameter int unsigned WIN_SCORE        = DEF_WIN_SCORE,
   parameter int unsigned OVER_FRAMES      = DEF_OVER_FRAMES,
   parameter int unsigned SCORE_W          = DEF_SCORE_W
) (
   input  logic              clk_0,
   input  logic              rst,
   game_screen_ctrl_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(max3(BLINK_FRAMES, FRAMES_PER_COUNT, OVER_FRAMES)) + 1;
   localparam logic [CNT_W-1:0]   BLINK_TERM = CNT_W'(BLINK_FRAMES - 1);
   localparam logic [CNT_W-1:0]   COUNT_TERM = CNT_W'(FRAMES_PER_COUNT - 1);
   localparam logic [CNT_W-1:0]   OVER_TERM  = CNT_W'(OVER_FRAMES - 1);
   localparam logic [3:0]         DIGIT_INIT = 4'(COUNT_FROM);
   localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

   state_t             state;
   logic               show_title, show_start, show_count, show_winner;
   logic               winner, game_run, ball_serve;
   logic [3:0]         count_digit;
   logic [SCORE_W-1:0] score_p1, score_p2;

   logic               div_clr, div_done;
   logic [CNT_W-1:0]   div_term;
   logic               point_any;
   logic [SCORE_W-1:0] inc_p1, inc_p2, new_score;

   assign inc_p1    = score_p1 + SCORE_W'(1);
   assign inc_p2    = score_p2 + SCORE_W'(1);
   assign point_any = bus.point_p1 || bus.point_p2;
   assign new_score = bus.point_p1 ? inc_p1 : inc_p2;

   // One divider serves all three timers; PLAY holds it cleared so every
   // countdown starts from zero.
   always_comb begin
      div_clr  = 1'b0;
      div_term = BLINK_TERM;
      unique case (state)
         ST_ATTRACT:   div_clr = bus.key_press;
         ST_COUNTDOWN: div_term = COUNT_TERM;
         ST_PLAY:      div_clr = 1'b1;
         ST_GAME_OVER: div_term = OVER_TERM;
         default:      div_clr = 1'b1;
      endcase
   end

   frame_divider #(.CNT_W(CNT_W)) u_frame_divider (
      .clk  (clk_0),
      .rst  (rst),
      .clr  (div_clr),
      .tick (bus.frame_tick),
      .term (div_term),
      .done (div_done)
   );

   always_ff @(posedge clk_0 or posedge rst) begin
      if (rst) begin
         state       <= ST_ATTRACT;
         show_title  <= 1'b1;
         show_start  <= 1'b1;
         show_count  <= 1'b0;
         show_winner <= 1'b0;
         count_digit <= '0;
         winner      <= 1'b0;
         game_run    <= 1'b0;
         ball_serve  <= 1'b0;
         score_p1    <= '0;
         score_p2    <= '0;
      end else begin
         ball_serve <= 1'b0;
         unique case (state)
            ST_ATTRACT: begin
               if (bus.key_press) begin
                  state       <= ST_COUNTDOWN;
                  score_p1    <= '0;
                  score_p2    <= '0;
                  count_digit <= DIGIT_INIT;
                  show_start  <= 1'b1;
                  show_title  <= 1'b0;
                  show_count  <= 1'b1;
               end else if (div_done) begin
                  show_start <= ~show_start;
               end
            end
            ST_COUNTDOWN: begin
               if (div_done) begin
                  if (count_digit == 4'd1) begin
                     state      <= ST_PLAY;
                     show_count <= 1'b0;
                     game_run   <= 1'b1;
                     ball_serve <= 1'b1;
                  end else begin
                     count_digit <= count_digit - 4'd1;
                  end
               end
            end
            ST_PLAY: begin
               if (point_any) begin
                  game_run <= 1'b0;
                  if (bus.point_p1) score_p1 <= inc_p1;
                  else              score_p2 <= inc_p2;
                  if (new_score == WIN_VAL) begin
                     state       <= ST_GAME_OVER;
                     winner      <= !bus.point_p1;
                     show_winner <= 1'b1;
                     show_title  <= 1'b1;
                  end else begin
                     state       <= ST_COUNTDOWN;
                     show_count  <= 1'b1;
                     count_digit <= DIGIT_INIT;
                  end
               end
            end
            ST_GAME_OVER: begin
               if (div_done) begin
                  state       <= ST_ATTRACT;
                  show_winner <= 1'b0;
               end
            end
            default: state <= ST_ATTRACT;
         endcase
      end
   end

   assign bus.show_title  = show_title;
   assign bus.show_start  = show_start;
   assign bus.show_count  = show_count;
   assign bus.count_digit = count_digit;
   assign bus.show_winner = show_winner;
   assign bus.winner      = winner;
   assign bus.game_run    = game_run;
   assign bus.ball_serve  = ball_serve;
   assign bus.score_p1    = score_p1;
   assign bus.score_p2    = score_p2;
endmodule

// File: tb/tb_game_screen_ctrl.sv
// Directed bench for game_screen_ctrl with short frame parameters; expected
// values are hand-derived from the screen sequencing rules.
module tb_game_screen_ctrl;
   logic clk_0 = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk_0 = ~clk_0;

   game_screen_ctrl_if #(.SCORE_W(4)) bus ();

   game_screen_ctrl #(
      .BLINK_FRAMES     (2),
      .COUNT_FROM       (3),
      .FRAMES_PER_COUNT (2),
      .WIN_SCORE        (2),
      .OVER_FRAMES      (3),
      .SCORE_W          (4)
   ) dut (
      .clk_0 (clk_0),
      .rst   (rst),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one clock of inputs, return #1 after the capturing edge.
   task automatic cyc(input logic ft, input logic kp, input logic a, input logic b);
      bus.frame_tick = ft;
      bus.key_press  = kp;
      bus.point_p1   = a;
      bus.point_p2   = b;
      @(posedge clk_0);
      #1;
      bus.frame_tick = 1'b0;
      bus.key_press  = 1'b0;
      bus.point_p1   = 1'b0;
      bus.point_p2   = 1'b0;
   endtask

   task automatic countdown_to_play();
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("enter_play_run", 32'(bus.game_run), 32'd1);
   endtask

   logic blink_exp [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [3:0] digit_exp [5] = '{4'd3, 4'd2, 4'd2, 4'd1, 4'd1};

   initial begin
      rst = 1'b1;
      bus.frame_tick = 1'b0;
      bus.key_press  = 1'b0;
      bus.point_p1   = 1'b0;
      bus.point_p2   = 1'b0;
      repeat (2) @(posedge clk_0);
      #1;
      chk("rst_title", 32'(bus.show_title), 32'd1);
      chk("rst_start", 32'(bus.show_start), 32'd1);
      chk("rst_count", 32'(bus.show_count), 32'd0);
      chk("rst_digit", 32'(bus.count_digit), 32'd0);
      chk("rst_run",   32'(bus.game_run), 32'd0);
      chk("rst_winner_en", 32'(bus.show_winner), 32'd0);
      rst = 1'b0;

      // 1: blink toggles on every second tick
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0);
         chk($sformatf("blink_%0d", i), 32'(bus.show_start), 32'(blink_exp[i]));
      end
      chk("attract_title", 32'(bus.show_title), 32'd1);

      // 2: key_press with a terminal frame_tick in the same cycle; key wins
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("cd_show",  32'(bus.show_count), 32'd1);
      chk("cd_digit", 32'(bus.count_digit), 32'd3);
      chk("cd_start", 32'(bus.show_start), 32'd1);
      chk("cd_title", 32'(bus.show_title), 32'd0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      chk("cd_ignore_digit", 32'(bus.count_digit), 32'd3);
      chk("cd_ignore_p1", 32'(bus.score_p1), 32'd0);
      chk("cd_ignore_p2", 32'(bus.score_p2), 32'd0);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0);
         chk($sformatf("cd_digit_%0d", i), 32'(bus.count_digit), 32'(digit_exp[i]));
      end
      chk("cd_pre_run", 32'(bus.game_run), 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("play_run",   32'(bus.game_run), 32'd1);
      chk("play_serve", 32'(bus.ball_serve), 32'd1);
      chk("play_count", 32'(bus.show_count), 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("serve_drop", 32'(bus.ball_serve), 32'd0);
      chk("play_tick_ignored", 32'(bus.game_run), 32'd1);

      // 3: p2 scores, back to countdown where points are ignored
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("p2_score", 32'(bus.score_p2), 32'd1);
      chk("p2_cd",    32'(bus.show_count), 32'd1);
      chk("p2_digit", 32'(bus.count_digit), 32'd3);
      chk("p2_run",   32'(bus.game_run), 32'd0);
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      chk("cd_pts_p1", 32'(bus.score_p1), 32'd0);
      chk("cd_pts_p2", 32'(bus.score_p2), 32'd1);
      countdown_to_play();

      // 4: simultaneous points, p1 has priority
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      chk("both_p1", 32'(bus.score_p1), 32'd1);
      chk("both_p2", 32'(bus.score_p2), 32'd1);
      countdown_to_play();

      // 5: p1 reaches WIN_SCORE
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("win_p1",     32'(bus.score_p1), 32'd2);
      chk("win_show",   32'(bus.show_winner), 32'd1);
      chk("win_who",    32'(bus.winner), 32'd0);
      chk("win_run",    32'(bus.game_run), 32'd0);
      chk("win_title",  32'(bus.show_title), 32'd1);
      chk("win_count",  32'(bus.show_count), 32'd0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("over_key_ignored", 32'(bus.show_winner), 32'd1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("over_hold", 32'(bus.show_winner), 32'd1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("over_done",  32'(bus.show_winner), 32'd0);
      chk("back_title", 32'(bus.show_title), 32'd1);
      chk("back_start", 32'(bus.show_start), 32'd1);
      chk("held_p1",    32'(bus.score_p1), 32'd2);
      chk("held_p2",    32'(bus.score_p2), 32'd1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("clr_p1",   32'(bus.score_p1), 32'd0);
      chk("clr_p2",   32'(bus.score_p2), 32'd0);
      chk("clr_show", 32'(bus.show_count), 32'd1);

      // 6: async reset between edges during countdown
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("pre_rst_digit", 32'(bus.count_digit), 32'd2);
      #2 rst = 1'b1;
      #1;
      chk("arst_count", 32'(bus.show_count), 32'd0);
      chk("arst_digit", 32'(bus.count_digit), 32'd0);
      chk("arst_title", 32'(bus.show_title), 32'd1);
      chk("arst_start", 32'(bus.show_start), 32'd1);
      @(posedge clk_0);
      #1 rst = 1'b0;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("post_rst_blink1", 32'(bus.show_start), 32'd1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("post_rst_blink2", 32'(bus.show_start), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
